// File: rtl/jam_pkg.sv
// Shared types and helpers for the jam_assign_search job-assignment engine.
package jam_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SUM,
        CMP,
        PIVOT,
        SUCC,
        REV,
        DONE
    } jam_state_t;

    // Index width for n workers; never narrower than one bit.
    function automatic int jam_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/jam_perm_step.sv
// Permutation register file for jam_assign_search: identity load, pivot/successor
// compares and the swap / suffix-reverse steps of lexicographic next-permutation.
module jam_perm_step
    import jam_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = jam_idx_w(N)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 load_id,
    input  logic                 do_swap,
    input  logic                 do_rev,
    input  logic [IDX_W-1:0]     pivot_idx,
    input  logic [IDX_W-1:0]     succ_idx,
    output logic [N*IDX_W-1:0]   perm_flat,
    output logic                 pivot_found,
    output logic                 succ_found
);

    function automatic logic [IDX_W-1:0] perm_at(input logic [IDX_W-1:0] idx);
        return perm_flat[idx*IDX_W +: IDX_W];
    endfunction

    logic [IDX_W-1:0] pivot_plus_one;
    assign pivot_plus_one = pivot_idx + 1'b1;

    assign pivot_found = perm_at(pivot_idx) < perm_at(pivot_plus_one);
    assign succ_found  = perm_at(succ_idx)  > perm_at(pivot_idx);

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cell
            logic [IDX_W-1:0] cell_reg;
            logic [IDX_W-1:0] cell_next;
            logic [IDX_W-1:0] mirror_idx;

            // Position in the suffix p+1..N-1 that lands here after reversal.
            assign mirror_idx = IDX_W'(N + int'(pivot_idx) - gi);

            always_comb begin
                cell_next = cell_reg;
                if (load_id) begin
                    cell_next = IDX_W'(gi);
                end else if (do_swap) begin
                    if (pivot_idx == IDX_W'(gi)) begin
                        cell_next = perm_at(succ_idx);
                    end else if (succ_idx == IDX_W'(gi)) begin
                        cell_next = perm_at(pivot_idx);
                    end
                end else if (do_rev && (IDX_W'(gi) > pivot_idx)) begin
                    cell_next = perm_at(mirror_idx);
                end
            end

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    cell_reg <= IDX_W'(gi);
                end else begin
                    cell_reg <= cell_next;
                end
            end

            assign perm_flat[gi*IDX_W +: IDX_W] = cell_reg;
        end
    endgenerate

endmodule

// File: rtl/jam_assign_search.sv
// Exhaustive job-assignment search over all N! permutations with min/count/best tracking.
// Optional JAM_PRUNE_EN aborts a permutation once its partial sum exceeds MinCost.
module jam_assign_search
    import jam_pkg::*;
#(
    parameter  int N      = 8,
    parameter  int COST_W = 7,
    parameter  int CNT_W  = 16,
    localparam int IDX_W  = jam_idx_w(N),
    localparam int SUM_W  = COST_W + IDX_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Start,
    output logic [IDX_W-1:0]     W,
    output logic [IDX_W-1:0]     J,
    input  logic [COST_W-1:0]    Cost,
    output logic                 Busy,
    output logic                 Valid,
    output logic [SUM_W-1:0]     MinCost,
    output logic [CNT_W-1:0]     MatchCount,
    output logic [N*IDX_W-1:0]   BestPerm
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] PIVOT_TOP = IDX_W'(N - 2);

    jam_state_t         state_reg;
    logic [IDX_W-1:0]   counter_reg;
    logic [IDX_W-1:0]   pivot_reg;
    logic [IDX_W-1:0]   succ_reg;
    logic [SUM_W-1:0]   sum_reg;
    logic [SUM_W-1:0]   min_reg;
    logic [CNT_W-1:0]   match_reg;
    logic [N*IDX_W-1:0] best_reg;
    logic               busy_reg;
    logic               valid_reg;

    logic [N*IDX_W-1:0] perm_flat;
    logic [N*IDX_W-1:0] ident_flat;
    logic               pivot_found;
    logic               succ_found;
    logic               start_ok;
    logic               prune_hit;
    logic [SUM_W-1:0]   sum_next;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ident
            assign ident_flat[gi*IDX_W +: IDX_W] = IDX_W'(gi);
        end
    endgenerate

    assign start_ok = Start && ((state_reg == IDLE) || (state_reg == DONE));
    assign sum_next = sum_reg + SUM_W'(Cost);

`ifdef JAM_PRUNE_EN
    // A partial sum already above the best total can never tie or win.
    assign prune_hit = (sum_next > min_reg);
`else
    assign prune_hit = 1'b0;
`endif

    jam_perm_step #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_perm (
        .CLK         (CLK),
        .RST         (RST),
        .load_id     (start_ok),
        .do_swap     ((state_reg == SUCC) && succ_found),
        .do_rev      (state_reg == REV),
        .pivot_idx   (pivot_reg),
        .succ_idx    (succ_reg),
        .perm_flat   (perm_flat),
        .pivot_found (pivot_found),
        .succ_found  (succ_found)
    );

    assign W          = counter_reg;
    assign J          = perm_flat[counter_reg*IDX_W +: IDX_W];
    assign Busy       = busy_reg;
    assign Valid      = valid_reg;
    assign MinCost    = min_reg;
    assign MatchCount = match_reg;
    assign BestPerm   = best_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= IDLE;
            counter_reg <= '0;
            pivot_reg   <= '0;
            succ_reg    <= '0;
            sum_reg     <= '0;
            min_reg     <= '1;
            match_reg   <= '0;
            best_reg    <= ident_flat;
            busy_reg    <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (Start) begin
                        min_reg     <= '1;
                        match_reg   <= '0;
                        sum_reg     <= '0;
                        counter_reg <= '0;
                        valid_reg   <= 1'b0;
                        busy_reg    <= 1'b1;
                        state_reg   <= SUM;
                    end
                end
                SUM: begin
                    if (prune_hit) begin
                        sum_reg     <= '0;
                        counter_reg <= '0;
                        pivot_reg   <= PIVOT_TOP;
                        state_reg   <= PIVOT;
                    end else if (counter_reg == LAST_IDX) begin
                        sum_reg     <= sum_next;
                        counter_reg <= '0;
                        state_reg   <= CMP;
                    end else begin
                        sum_reg     <= sum_next;
                        counter_reg <= counter_reg + 1'b1;
                    end
                end
                CMP: begin
                    // Strict less-than keeps the lexicographically first optimum.
                    if (sum_reg < min_reg) begin
                        min_reg   <= sum_reg;
                        match_reg <= CNT_W'(1);
                        best_reg  <= perm_flat;
                    end else if ((sum_reg == min_reg) && (match_reg != '1)) begin
                        match_reg <= match_reg + 1'b1;
                    end
                    sum_reg   <= '0;
                    pivot_reg <= PIVOT_TOP;
                    state_reg <= PIVOT;
                end
                PIVOT: begin
                    if (pivot_found) begin
                        succ_reg  <= LAST_IDX;
                        state_reg <= SUCC;
                    end else if (pivot_reg == '0) begin
                        busy_reg  <= 1'b0;
                        valid_reg <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        pivot_reg <= pivot_reg - 1'b1;
                    end
                end
                SUCC: begin
                    if (succ_found) begin
                        state_reg <= REV;
                    end else begin
                        succ_reg <= succ_reg - 1'b1;
                    end
                end
                REV: begin
                    counter_reg <= '0;
                    state_reg   <= SUM;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jam_assign_search.sv
// Bench for jam_assign_search: two instances (N=5 and N=4 with a 4-bit counter)
// checked against a brute-force tuple-enumeration model of the search.
module tb_jam_assign_search;

    localparam int NA   = 5;
    localparam int NB   = 4;
    localparam int CW   = 7;
    localparam int CNTA = 16;
    localparam int CNTB = 4;
    localparam int IWA  = 3;
    localparam int IWB  = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;

    logic [IWA-1:0]     w_a, j_a;
    logic [CW-1:0]      cost_in_a;
    logic               busy_a, valid_a;
    logic [CW+IWA-1:0]  min_a;
    logic [CNTA-1:0]    cnt_a;
    logic [NA*IWA-1:0]  best_a;

    logic [IWB-1:0]     w_b, j_b;
    logic [CW-1:0]      cost_in_b;
    logic               busy_b, valid_b;
    logic [CW+IWB-1:0]  min_b;
    logic [CNTB-1:0]    cnt_b;
    logic [NB*IWB-1:0]  best_b;

    int cost_a [NA][NA];
    int cost_b [NB][NB];

    int vectors     = 0;
    int miscompares = 0;
    int exp_min  [2];
    int exp_cnt  [2];
    int exp_best [2];
    int exp_cyc  [2];
    bit chk      [2] = '{1'b0, 1'b0};

    always #5 CLK = ~CLK;

    assign cost_in_a = CW'(cost_a[w_a][j_a]);
    assign cost_in_b = CW'(cost_b[w_b][j_b]);

    jam_assign_search #(.N(NA), .COST_W(CW), .CNT_W(CNTA)) dut_a (
        .CLK(CLK), .RST(RST), .Start(start_a), .W(w_a), .J(j_a), .Cost(cost_in_a),
        .Busy(busy_a), .Valid(valid_a), .MinCost(min_a), .MatchCount(cnt_a), .BestPerm(best_a)
    );

    jam_assign_search #(.N(NB), .COST_W(CW), .CNT_W(CNTB)) dut_b (
        .CLK(CLK), .RST(RST), .Start(start_b), .W(w_b), .J(j_b), .Cost(cost_in_b),
        .Busy(busy_b), .Valid(valid_b), .MinCost(min_b), .MatchCount(cnt_b), .BestPerm(best_b)
    );

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic valid_of(input int which);
        return (which == 0) ? valid_a : valid_b;
    endfunction

    function automatic logic busy_of(input int which);
        return (which == 0) ? busy_a : busy_b;
    endfunction

    function automatic int cost_of(input int which, input int w, input int j);
        return (which == 0) ? cost_a[w][j] : cost_b[w][j];
    endfunction

    task automatic set_start(input int which, input logic v);
        if (which == 0) start_a = v;
        else            start_b = v;
    endtask

    // mode 0: random 0..v, 1: all v, 2: 0 on diagonal else v, 3: 0 on anti-diagonal else v
    task automatic fill(input int which, input int mode, input int v);
        int n;
        int c;
        n = (which == 0) ? NA : NB;
        for (int w = 0; w < n; w++) begin
            for (int j = 0; j < n; j++) begin
                case (mode)
                    0:       c = int'($urandom_range(v, 0));
                    1:       c = v;
                    2:       c = (j == w) ? 0 : v;
                    default: c = (j == n - 1 - w) ? 0 : v;
                endcase
                if (which == 0) cost_a[w][j] = c;
                else            cost_b[w][j] = c;
            end
        end
    endtask

    // Walk all n^n tuples (worker 0 most significant); the ones that are permutations
    // come out in lexicographic order. Also totals the expected busy-cycle count.
    task automatic model(input int which);
        int n, iw, cmax, total, rem, mask, s, mn, cnt, best, cyc, p, q;
        int d[8];
        int prev[8];
        bit have_prev;
        bit ok;
        n    = (which == 0) ? NA : NB;
        iw   = (which == 0) ? IWA : IWB;
        cmax = (1 << ((which == 0) ? CNTA : CNTB)) - 1;
        total = 1;
        for (int i = 0; i < n; i++) total *= n;
        mn = 32'h7fff_ffff; cnt = 0; best = 0; cyc = 0; have_prev = 1'b0;
        for (int code = 0; code < total; code++) begin
            rem = code;
            for (int w = n - 1; w >= 0; w--) begin
                d[w] = rem % n;
                rem  = rem / n;
            end
            mask = 0; ok = 1'b1;
            for (int w = 0; w < n; w++) begin
                if (mask[d[w]]) ok = 1'b0;
                mask[d[w]] = 1'b1;
            end
            if (ok) begin
                if (have_prev) begin
                    p = 0;
                    for (int i = 0; i <= n - 2; i++) if (prev[i] < prev[i+1]) p = i;
                    q = p + 1;
                    for (int i = p + 1; i < n; i++) if (prev[i] > prev[p]) q = i;
                    cyc += (n - 1 - p) + (n - q) + 1;
                end
                cyc += n + 1;
                s = 0;
                for (int w = 0; w < n; w++) s += cost_of(which, w, d[w]);
                if (s < mn) begin
                    mn = s; cnt = 1; best = 0;
                    for (int w = 0; w < n; w++) best |= d[w] << (w * iw);
                end else if (s == mn && cnt < cmax) begin
                    cnt++;
                end
                prev = d;
                have_prev = 1'b1;
            end
        end
        cyc += n - 1;
        exp_min[which]  = mn;
        exp_cnt[which]  = cnt;
        exp_best[which] = best;
        exp_cyc[which]  = cyc;
    endtask

    task automatic run(input int which, input bit fewer, input int extra_at, input string tag);
        int cycles;
        chk[which] = 1'b0;
        model(which);
        @(negedge CLK); set_start(which, 1'b1);
        @(negedge CLK); set_start(which, 1'b0);
        check({tag, " Busy after Start"}, busy_of(which), 1);
        check({tag, " Valid dropped"}, valid_of(which), 0);
        chk[which] = 1'b1;
        cycles = 0;
        while (!valid_of(which) && cycles < 20000) begin
            if (busy_of(which)) cycles++;
            @(negedge CLK);
            set_start(which, (extra_at != 0) && (cycles == extra_at));
        end
        set_start(which, 1'b0);
        check({tag, " Valid reached"}, valid_of(which), 1);
        check({tag, " Busy low in DONE"}, busy_of(which), 0);
`ifdef JAM_PRUNE_EN
        if (fewer) check({tag, " pruned cycles fewer"}, int'(cycles < exp_cyc[which]), 1);
        else       check({tag, " pruned cycles bound"}, int'(cycles <= exp_cyc[which]), 1);
`else
        check({tag, " busy cycles"}, cycles, exp_cyc[which]);
`endif
        $display("run %s: min=%0d count=%0d best=0x%0h busy_cycles=%0d", tag,
                 exp_min[which], exp_cnt[which], exp_best[which], cycles);
        repeat (2) @(negedge CLK);
    endtask

    // Results must match the model on every cycle they are flagged valid.
    always @(negedge CLK) begin
        if (chk[0] && valid_a) begin
            check("A MinCost", int'(min_a), exp_min[0]);
            check("A MatchCount", int'(cnt_a), exp_cnt[0]);
            check("A BestPerm", int'(best_a), exp_best[0]);
        end
        if (chk[0] && busy_a) check("A W/J range", int'(w_a < NA && j_a < NA), 1);
        if (chk[1] && valid_b) begin
            check("B MinCost", int'(min_b), exp_min[1]);
            check("B MatchCount", int'(cnt_b), exp_cnt[1]);
            check("B BestPerm", int'(best_b), exp_best[1]);
        end
        if (chk[1] && busy_b) check("B W/J range", int'(w_b < NB && j_b < NB), 1);
    end

    initial begin
        fill(0, 1, 0);
        fill(1, 1, 0);
        repeat (2) @(negedge CLK);
        check("A reset Busy", busy_a, 0);
        check("A reset Valid", valid_a, 0);
        check("A reset MinCost", int'(min_a), 1023);
        check("A reset MatchCount", int'(cnt_a), 0);
        check("A reset BestPerm", int'(best_a), 18056);
        check("A reset W", int'(w_a), 0);
        check("A reset J", int'(j_a), 0);
        check("B reset MinCost", int'(min_b), 511);
        check("B reset BestPerm", int'(best_b), 228);
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        fill(0, 1, 1);
        run(0, 1'b0, 0, "A all-ones");
        check("model pin A ones count", exp_cnt[0], 120);
        check("A ones MinCost", int'(min_a), 5);
        check("A ones MatchCount", int'(cnt_a), 120);
        check("A ones BestPerm", int'(best_a), 18056);

        fill(0, 2, 50);
        run(0, 1'b1, 0, "A diagonal");
        check("A diag MinCost", int'(min_a), 0);
        check("A diag MatchCount", int'(cnt_a), 1);
        check("A diag BestPerm", int'(best_a), 18056);

        fill(0, 3, 100);
        run(0, 1'b1, 0, "A anti-diagonal");
        check("model pin A anti best", exp_best[0], 668);
        check("A anti MinCost", int'(min_a), 0);
        check("A anti MatchCount", int'(cnt_a), 1);
        check("A anti BestPerm", int'(best_a), 668);

        fill(0, 0, 127);
        run(0, 1'b0, 15, "A start-while-busy");
        run(0, 1'b0, 0, "A restart from DONE");

        // Reset in the middle of the first permutation's SUM phase.
        chk[0] = 1'b0;
        fill(0, 0, 127);
        @(negedge CLK); start_a = 1'b1;
        @(negedge CLK); start_a = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("A midreset Busy", busy_a, 0);
        check("A midreset Valid", valid_a, 0);
        check("A midreset MinCost", int'(min_a), 1023);
        check("A midreset MatchCount", int'(cnt_a), 0);
        check("A midreset W", int'(w_a), 0);
        check("A midreset BestPerm", int'(best_a), 18056);
        @(negedge CLK); RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("A no resume Busy", busy_a, 0);
        check("A no resume Valid", valid_a, 0);
        run(0, 1'b0, 0, "A after reset");

        for (int k = 0; k < 4; k++) begin
            fill(0, 0, 127);
            run(0, 1'b0, 0, "A random");
        end
        for (int k = 0; k < 2; k++) begin
            fill(0, 0, 2);
            run(0, 1'b0, 0, "A random ties");
        end

        fill(1, 1, 3);
        run(1, 1'b0, 0, "B all-equal saturate");
        check("B sat MinCost", int'(min_b), 12);
        check("B sat MatchCount", int'(cnt_b), 15);
        check("B sat BestPerm", int'(best_b), 228);
        for (int k = 0; k < 2; k++) begin
            fill(1, 0, 1);
            run(1, 1'b0, 0, "B random ties");
        end
        fill(1, 0, 127);
        run(1, 1'b0, 0, "B random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
